// File: rtl/bram_stream_reader.sv
// Burst read controller for one block-RAM port: fetches `length` words from `base_addr`
// and streams them out with valid/ready and last-word marking through a 2-entry skid buffer.
module bram_stream_reader #(
  parameter int unsigned N = 8,
  parameter int unsigned B = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] base_addr,
  input  logic [N:0]   length,
  output logic         busy,
  output logic         done,
  output logic         mem_en,
  output logic         mem_re,
  output logic [N-1:0] mem_addr,
  input  logic [B-1:0] mem_dout,
  output logic [B-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e       state_q, state_d;

  logic [N-1:0] base_q;
  // Only the low N bits of the length matter for addressing: offsets are taken modulo 2**N.
  logic [N-1:0] len_lo_q;
  logic [N:0]   issue_q;
  logic [N:0]   deliver_q;
  logic         inflight_q;
  logic [B-1:0] buf_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   occ_q;

  logic         accept;
  logic         pop;
  logic         push;
  logic [2:0]   level;
  logic         issue;

  always_comb begin
    accept = (state_q == IDLE) && start;
    pop    = (occ_q != 2'd0) && m_ready;
    push   = inflight_q;
    // Slots committed after this cycle: buffered + arriving - leaving.
    level  = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    issue  = (state_q == RUN) && (issue_q != '0) && (level < 3'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (length != '0) ? RUN : FIN;
        end
      end
      RUN: begin
        if (pop && (deliver_q == (N+1)'(1))) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy     = (state_q == RUN);
    done     = (state_q == FIN);
    mem_en   = issue;
    mem_re   = issue;
    mem_addr = base_q + len_lo_q - issue_q[N-1:0];
    m_valid  = (occ_q != 2'd0);
    m_data   = buf_q[rd_ptr_q];
    m_last   = m_valid && (deliver_q == (N+1)'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      len_lo_q   <= '0;
      issue_q    <= '0;
      deliver_q  <= '0;
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      if (accept) begin
        base_q    <= base_addr;
        len_lo_q  <= length[N-1:0];
        issue_q   <= length;
        deliver_q <= length;
      end else begin
        if (issue) begin
          issue_q <= issue_q - (N+1)'(1);
        end
        if (pop) begin
          deliver_q <= deliver_q - (N+1)'(1);
        end
      end

      inflight_q <= issue;

      if (push) begin
        buf_q[wr_ptr_q] <= mem_dout;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: expected addresses and words are queued at start
// and compared as reads issue and stream handshakes complete.
module tb_bram_stream_reader;

  localparam int unsigned N = 8;
  localparam int unsigned B = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] base_addr;
  logic [N:0]   length;
  logic         busy;
  logic         done;
  logic         mem_en;
  logic         mem_re;
  logic [N-1:0] mem_addr;
  logic [B-1:0] mem_dout = '0;
  logic [B-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;

  bram_stream_reader #(.N(N), .B(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_en    (mem_en),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  logic [B-1:0] ram [256];

  always @(posedge clk) begin
    if (mem_en && mem_re) mem_dout <= ram[mem_addr];
  end

  int n_total = 0;
  int n_bad   = 0;

  logic [N-1:0] addr_q [$];
  logic [B-1:0] data_q [$];
  logic         last_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_ram(input logic [B-1:0] offs);
    for (int i = 0; i < 256; i++) ram[i] = offs + B'(i);
  endtask

  task automatic flush_sb();
    addr_q.delete();
    data_q.delete();
    last_q.delete();
  endtask

  // mode 0: ready always 1, mode 1: 1,0,0,1,0,1 pattern, mode 2: random
  task automatic run_burst(input logic [N-1:0] base, input int unsigned len,
                           input int unsigned mode, input int unsigned abort_after,
                           input logic poke_start);
    int unsigned  k, budget, issued, delivered;
    int           outstanding, exp_issue;
    int unsigned  first_en, first_valid, last_k, done_k;
    logic         done_seen, inflight_prev, stall_prev, prev_last, pop;
    logic [B-1:0] prev_data, exp_d;
    logic [N-1:0] a, exp_a;
    logic         exp_l;
    logic         rpat [6];

    rpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int unsigned i = 0; i < len; i++) begin
      a = base + N'(i);
      addr_q.push_back(a);
      data_q.push_back(ram[a]);
      last_q.push_back(i == len - 1);
    end

    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    length    = (N+1)'(len);
    m_ready   = 1'b1;
    @(posedge clk);

    k = 0; budget = len * 6 + 20; issued = 0; delivered = 0;
    first_en = 0; first_valid = 0; last_k = 0; done_k = 0;
    done_seen = 1'b0; inflight_prev = 1'b0; stall_prev = 1'b0;
    prev_last = 1'b0; prev_data = '0;

    while (!done_seen && k < budget) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (poke_start && k == 5) begin
        start     = 1'b1;
        base_addr = base + 8'h40;
        length    = (N+1)'(3);
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = rpat[(k - 1) % 6];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      pop         = m_valid && m_ready;
      outstanding = int'(issued) - int'(delivered);
      exp_issue   = (issued < len) && (outstanding - int'(pop) < 2);

      if (k == 1) check("busy_first", 32'(busy), 32'(len != 0));
      check("issue_rule", 32'(mem_en), 32'(exp_issue));
      check("mem_re", 32'(mem_re), 32'(mem_en));
      check("valid_model", 32'(m_valid), 32'((outstanding - int'(inflight_prev)) != 0));
      check("occ_le2", 32'(outstanding <= 2), 32'(1));
      if (m_valid) check("m_last", 32'(m_last), 32'(delivered == len - 1));
      if (stall_prev) begin
        check("stall_valid", 32'(m_valid), 32'(1));
        check("stall_data", 32'(m_data), 32'(prev_data));
        check("stall_last", 32'(m_last), 32'(prev_last));
      end

      if (mem_en) begin
        if (addr_q.size() == 0) begin
          check("extra_read", 32'(addr_q.size()), 32'(1));
        end else begin
          exp_a = addr_q.pop_front();
          check("mem_addr", 32'(mem_addr), 32'(exp_a));
        end
        if (first_en == 0) first_en = k;
      end
      if (m_valid && first_valid == 0) first_valid = k;

      if (pop) begin
        if (data_q.size() == 0) begin
          check("extra_word", 32'(data_q.size()), 32'(1));
        end else begin
          exp_d = data_q.pop_front();
          exp_l = last_q.pop_front();
          check("m_data", 32'(m_data), 32'(exp_d));
          check("m_last_pop", 32'(m_last), 32'(exp_l));
        end
        if (m_last) last_k = k;
        delivered++;
      end
      if (done) begin
        done_seen = 1'b1;
        done_k    = k;
      end

      issued        = issued + 32'(mem_en);
      inflight_prev = mem_en;
      stall_prev    = m_valid && !m_ready;
      prev_data     = m_data;
      prev_last     = m_last;

      if (abort_after != 0 && delivered == abort_after) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort_outs", 32'({busy, done, mem_en, mem_re, mem_addr, m_valid, m_last, m_data}), 32'(0));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("abort_held", 32'({busy, done, mem_en, m_valid}), 32'(0));
        rst_n = 1'b1;
        flush_sb();
        return;
      end
    end

    check("done_seen", 32'(done_seen), 32'(1));
    check("delivered", 32'(delivered), 32'(len));
    check("sb_empty", 32'(data_q.size() + addr_q.size()), 32'(0));
    if (mode == 0) begin
      check("done_cycle", 32'(done_k), 32'(len + 3 - 2 * (len == 0)));
      if (len != 0) begin
        check("first_en", 32'(first_en), 32'(1));
        check("first_valid", 32'(first_valid), 32'(3));
        check("last_cycle", 32'(last_k), 32'(len + 2));
      end else begin
        check("empty_noread", 32'(first_en + first_valid), 32'(0));
      end
    end
    flush_sb();

    @(negedge clk);
    start = 1'b0;
    #1;
    check("after_done", 32'({busy, done, mem_en, m_valid}), 32'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1'b0;
    fill_ram(16'h1000);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start     = 1'($urandom_range(0, 1));
      base_addr = N'($urandom);
      length    = (N+1)'($urandom);
      m_ready   = 1'($urandom_range(0, 1));
      #1;
      check("rst_outs", 32'({busy, done, mem_en, mem_re, mem_addr, m_valid, m_last, m_data}), 32'(0));
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("idle_no_read", 32'({mem_en, busy, done}), 32'(0));
    end

    run_burst(8'h10, 4, 0, 0, 1'b0);
    run_burst(8'hFE, 4, 0, 0, 1'b0);
    run_burst(8'h20, 8, 1, 0, 1'b1);
    run_burst(8'h00, 0, 0, 0, 1'b0);
    run_burst(8'h80, 256, 0, 0, 1'b0);
    run_burst(8'h33, 20, 2, 0, 1'b1);
    run_burst(8'h40, 8, 0, 3, 1'b0);
    fill_ram(16'h2000);
    run_burst(8'h10, 4, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side controller for the team's dual-port block RAM. It drives one RAM port (en/re/addr, 1-cycle registered read data) to fetch a burst of `length` words starting at `base_addr`. It delivers them as a valid/ready stream with last-word marking to the downstream consumer. A 2-entry output buffer absorbs the RAM read latency, so the stream sustains one word per clock under continuous `m_ready` and never loses data under backpressure.

## Interface
- N, 8, RAM address width (depth 2**N)
- B, 16, RAM data width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  burst request, sampled in IDLE only
- base_addr  in  N  first RAM address of burst, captured with start
- length  in  N+1  number of words, captured with start; 0 = empty burst
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse at burst completion
- mem_en  out  1  RAM port enable
- mem_re  out  1  RAM read enable, always equal to mem_en
- mem_addr  out  N  RAM read address
- mem_dout  in  B  RAM read data, valid the cycle after mem_en&mem_re
- m_data  out  B  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  consumer ready
- m_last  out  1  marks final word of burst, qualified by m_valid

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE: if start=1 and length!=0, capture base_addr/length and go to RUN. If start=1 and length=0, go to FIN. Otherwise hold.
- RUN: issue reads and forward data. Go to FIN in the cycle after the last word handshake (m_valid&m_ready&m_last).
- FIN: done=1 for exactly one cycle, then unconditionally go to IDLE. start is ignored in RUN and FIN.
- Issue counter (N+1 bits) holds words still to read. Deliver counter (N+1 bits) holds words still to hand off. Both load `length` on start.
- Issue rule, evaluated each RUN cycle: mem_en=1 iff issue_cnt!=0 and (occ + inflight − pop) < 2.
  - occ: buffer entries (0..2).
  - inflight: mem_en in the previous cycle.
  - pop: m_valid&m_ready this cycle.
  - mem_en therefore depends combinationally on m_ready.
- mem_addr = base_addr + (length − issue_cnt), modulo 2**N. Addresses wrap past 2**N−1 to 0. Lengths above 2**N re-read from wrapped addresses.
- The data cycle after each issue writes mem_dout into the buffer tail. The buffer can never overflow, by the issue rule.
- m_valid = (occ!=0). m_data = buffer head. m_last = m_valid & (deliver_cnt==1).
- While m_valid&!m_ready, m_data and m_last hold stable.

## Timing
- Reset (async assert, sync release): state=IDLE, counters=0, occ=0, inflight=0, and busy, done, mem_en, mem_re, mem_addr, m_valid, m_last, m_data all 0.
- Reset mid-burst aborts immediately. Any in-flight read is discarded and no done pulse is produced.
- start sampled at edge E0: busy=1 and first mem_en in cycle E0+1. First m_valid in cycle E0+3 (2 cycles after first mem_en).
- With m_ready held 1: one word per cycle. A burst of L words has m_last in cycle E0+2+L, done in E0+3+L, and a new start is accepted at the end of E0+4+L.
- Empty burst: start at E0 gives done in E0+1, with no mem_en and no m_valid.
- If m_ready is dropped, at most 2 words are buffered and issue stalls. When m_ready rises, issue resumes the same cycle.
- A simultaneous push and pop in the same cycle leaves occ unchanged.

## Test plan
- Reset: hold rst_n=0 with random inputs. All outputs must be 0. Release and wait 5 idle cycles: no mem_en.
- Basic burst: RAM[i]=0x1000+i, base=0x10, length=4, m_ready=1. Required: mem_addr 0x10..0x13 on consecutive cycles; m_data 0x1010..0x1013 on consecutive cycles; m_last only on 0x1013; single done pulse; full throughput.
- Wrap: base=0xFE, length=4. Required: addresses 0xFE, 0xFF, 0x00, 0x01, and data in that order.
- Backpressure: length=8, m_ready toggling 1,0,0,1,0,1 … Required: all 8 words delivered exactly once, in order; m_data stable while stalled; occ never exceeds 2; no read issued while buffer+inflight is full.
- Edge lengths and ignored start: length=0 gives done next cycle with no reads. length=256 with N=8 gives 256 words with m_last on the 256th. start pulsed during RUN is ignored.
- Abort: assert rst_n=0 mid-burst after 3 words. Required: outputs 0 immediately. A new burst after release delivers fresh data with no stale word.
